// File: rtl/data_dist.sv
// data_dist: routes input bytes to four independent 2-entry FIFOs, unicast or broadcast.
module data_dist (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  din,
  input  logic [2:0]  dsel,
  output logic [3:0]  dout_valid,
  input  logic [3:0]  dout_ready,
  output logic [31:0] dout,
  output logic [7:0]  level
);
  logic [3:0] full, push, pop;
  assign din_ready = !rst && (dsel[2] ? ~|full : !full[dsel[1:0]]);
  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [7:0] hd_q, hd_d, tl_q, tl_d;
    logic [1:0] lvl_q, lvl_d, pos;
    assign full[i]          = lvl_q[1];
    assign dout_valid[i]    = lvl_q != 2'd0;
    assign dout[8*i +: 8]   = dout_valid[i] ? hd_q : 8'h00;
    assign level[2*i +: 2]  = lvl_q;
    assign push[i] = din_valid && din_ready && (dsel[2] || dsel[1:0] == 2'(i));
    assign pop[i]  = dout_valid[i] && dout_ready[i];
    // slot the pushed byte lands in, after this cycle's pop has shifted the tail forward
    assign pos   = lvl_q - {1'b0, pop[i]};
    assign hd_d  = (push[i] && pos == 2'd0) ? din : pop[i] ? tl_q : hd_q;
    assign tl_d  = (push[i] && pos == 2'd1) ? din : tl_q;
    assign lvl_d = lvl_q + {1'b0, push[i]} - {1'b0, pop[i]};
    always_ff @(posedge clk) begin
      if (rst) begin
        hd_q  <= 8'h00;
        tl_q  <= 8'h00;
        lvl_q <= 2'd0;
      end else begin
        hd_q  <= hd_d;
        tl_q  <= tl_d;
        lvl_q <= lvl_d;
      end
    end
  end
endmodule

// File: tb/tb_data_dist.sv
// tb_data_dist: directed vector table plus randomized traffic against a queue-based model.
module tb_data_dist;
  logic clk = 1'b0;
  logic rst, din_valid, din_ready;
  logic [7:0] din, level;
  logic [2:0] dsel;
  logic [3:0] dout_valid, dout_ready;
  logic [31:0] dout;
  int checks = 0, failures = 0;
  logic [7:0] mq [4][$];

  always #5 clk = ~clk;

  data_dist dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .dsel(dsel), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .level(level)
  );

  typedef struct {
    logic        r, v;
    logic [7:0]  d;
    logic [2:0]  s;
    logic [3:0]  rdy;
    logic        e_dr;
    logic [3:0]  e_dv;
    logic [31:0] e_do;
    logic [7:0]  e_lv;
  } vec_t;
  vec_t tbl [26];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic logic m_ready();
    if (rst) return 1'b0;
    if (dsel[2]) begin
      for (int c = 0; c < 4; c++) if (mq[c].size() >= 2) return 1'b0;
      return 1'b1;
    end
    return mq[dsel[1:0]].size() < 2;
  endfunction

  task automatic model_check();
    logic [3:0] dv;
    logic [31:0] dd;
    logic [7:0] lv;
    for (int c = 0; c < 4; c++) begin
      dv[c] = mq[c].size() != 0;
      dd[8*c +: 8] = mq[c].size() != 0 ? mq[c][0] : 8'h00;
      lv[2*c +: 2] = 2'(mq[c].size());
    end
    chk("model_din_ready", {31'b0, din_ready}, {31'b0, m_ready()});
    chk("model_dout_valid", {28'b0, dout_valid}, {28'b0, dv});
    chk("model_dout", dout, dd);
    chk("model_level", {24'b0, level}, {24'b0, lv});
  endtask

  task automatic drive(input logic r, v, input logic [7:0] d, input logic [2:0] s,
                       input logic [3:0] rdy, input bit mcheck);
    rst = r; din_valid = v; din = d; dsel = s; dout_ready = rdy;
    @(negedge clk);
    if (mcheck) model_check();
  endtask

  task automatic edge_step();
    logic acc;
    acc = din_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
    end else begin
      for (int c = 0; c < 4; c++)
        if (mq[c].size() != 0 && dout_ready[c]) void'(mq[c].pop_front());
      if (acc)
        for (int c = 0; c < 4; c++)
          if (dsel[2] || dsel[1:0] == 2'(c)) mq[c].push_back(din);
    end
    #1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 8'h00, 3'b000, 4'h0, 0, 4'h0, 32'h0, 8'h00};
    tbl[1]  = '{0, 1, 8'hA5, 3'b010, 4'h0, 1, 4'h0, 32'h0, 8'h00};
    tbl[2]  = '{0, 0, 8'h00, 3'b000, 4'h0, 1, 4'b0100, 32'h00A50000, 8'h10};
    tbl[3]  = '{1, 0, 8'h00, 3'b000, 4'h0, 0, 4'b0100, 32'h00A50000, 8'h10};
    tbl[4]  = '{0, 1, 8'h11, 3'b001, 4'h0, 1, 4'h0, 32'h0, 8'h00};
    tbl[5]  = '{0, 1, 8'h22, 3'b001, 4'h0, 1, 4'b0010, 32'h00001100, 8'h04};
    tbl[6]  = '{0, 0, 8'h00, 3'b001, 4'h0, 0, 4'b0010, 32'h00001100, 8'h08};
    tbl[7]  = '{0, 0, 8'h00, 3'b100, 4'h0, 0, 4'b0010, 32'h00001100, 8'h08};
    tbl[8]  = '{0, 0, 8'h00, 3'b111, 4'h0, 0, 4'b0010, 32'h00001100, 8'h08};
    tbl[9]  = '{0, 0, 8'h00, 3'b000, 4'h0, 1, 4'b0010, 32'h00001100, 8'h08};
    tbl[10] = '{0, 0, 8'h00, 3'b001, 4'b0010, 0, 4'b0010, 32'h00001100, 8'h08};
    tbl[11] = '{0, 0, 8'h00, 3'b000, 4'b0010, 1, 4'b0010, 32'h00002200, 8'h04};
    tbl[12] = '{0, 0, 8'h00, 3'b000, 4'b0010, 1, 4'h0, 32'h0, 8'h00};
    tbl[13] = '{1, 0, 8'h00, 3'b000, 4'h0, 0, 4'h0, 32'h0, 8'h00};
    tbl[14] = '{0, 1, 8'h3C, 3'b100, 4'h0, 1, 4'h0, 32'h0, 8'h00};
    tbl[15] = '{0, 1, 8'h77, 3'b011, 4'h0, 1, 4'hF, 32'h3C3C3C3C, 8'h55};
    tbl[16] = '{0, 1, 8'h99, 3'b100, 4'h0, 0, 4'hF, 32'h3C3C3C3C, 8'h95};
    tbl[17] = '{0, 1, 8'h99, 3'b100, 4'h0, 0, 4'hF, 32'h3C3C3C3C, 8'h95};
    tbl[18] = '{0, 1, 8'h99, 3'b100, 4'b1000, 0, 4'hF, 32'h3C3C3C3C, 8'h95};
    tbl[19] = '{0, 1, 8'h99, 3'b100, 4'h0, 1, 4'hF, 32'h773C3C3C, 8'h55};
    tbl[20] = '{0, 0, 8'h00, 3'b100, 4'h0, 0, 4'hF, 32'h773C3C3C, 8'hAA};
    tbl[21] = '{1, 1, 8'hEE, 3'b100, 4'hF, 0, 4'hF, 32'h773C3C3C, 8'hAA};
    tbl[22] = '{1, 0, 8'h00, 3'b000, 4'h0, 0, 4'h0, 32'h0, 8'h00};
    tbl[23] = '{0, 1, 8'h01, 3'b000, 4'h0, 1, 4'h0, 32'h0, 8'h00};
    tbl[24] = '{0, 1, 8'h02, 3'b000, 4'b0001, 1, 4'b0001, 32'h00000001, 8'h01};
    tbl[25] = '{0, 0, 8'h00, 3'b000, 4'h0, 1, 4'b0001, 32'h00000002, 8'h01};

    drive(1, 1, 8'hFF, 3'b100, 4'hF, 0);
    edge_step();
    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].rdy, 1);
      chk($sformatf("vec%0d_din_ready", k), {31'b0, din_ready}, {31'b0, tbl[k].e_dr});
      chk($sformatf("vec%0d_dout_valid", k), {28'b0, dout_valid}, {28'b0, tbl[k].e_dv});
      chk($sformatf("vec%0d_dout", k), dout, tbl[k].e_do);
      chk($sformatf("vec%0d_level", k), {24'b0, level}, {24'b0, tbl[k].e_lv});
      edge_step();
    end

    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 59) == 0, 1'($urandom), 8'($urandom), 3'($urandom),
            4'($urandom), 1);
      edge_step();
    end
    drive(0, 0, 8'h00, 3'b000, 4'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_dist.md
DATA_DIST -- requirements
Module: data_dist

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din_valid  input  1  source presents a byte.
REQ-005 din_ready  output  1  block accepts the byte this cycle.
REQ-006 din  input  8  data byte.
REQ-007 dsel  input  3  destination; dsel[2]=1 means broadcast, otherwise unicast to channel dsel[1:0].
REQ-008 dout_valid  output  4  bit i: channel i head valid.
REQ-009 dout_ready  input  4  bit i: channel i sink takes head.
REQ-010 dout  output  32  channel i head byte on bits [8i+7:8i].
REQ-011 level  output  8  channel i occupancy (0..2) on bits [2i+1:2i].

Function
REQ-012 Each channel SHALL own an independent 2-entry FIFO; byte order per channel SHALL be preserved.
REQ-013 An input transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; an output pop on channel i SHALL occur where dout_valid[i]=1 and dout_ready[i]=1.
REQ-014 In unicast, din_ready SHALL be 1 iff level of channel dsel[1:0] < 2.
REQ-015 In broadcast, din_ready SHALL be 1 iff every channel level < 2; the transfer SHALL write din into all four FIFOs on the same edge.
REQ-016 din_ready SHALL depend only on registered levels, dsel and rst; there SHALL be no combinational path from dout_ready or din_valid to din_ready.
REQ-017 din_ready SHALL be 0 while rst=1.
REQ-018 Latency: a byte accepted on edge N into an empty channel SHALL appear on dout with dout_valid=1 in the cycle after edge N.
REQ-019 dout_valid[i] SHALL equal (level_i != 0); dout[8i+7:8i] SHALL be the oldest stored byte, and 8'h00 when level_i = 0.
REQ-020 Simultaneous push and pop on one channel at level 1 SHALL leave level at 1 with the pushed byte as new head.
REQ-021 Push only: level +1; pop only: level -1; neither: unchanged; level SHALL never exceed 2 nor underflow.
REQ-022 dout_ready[i] asserted while dout_valid[i]=0 SHALL have no effect.
REQ-023 dsel and din SHALL be ignored when din_valid=0; din_valid with din_ready=0 SHALL change no state.
REQ-024 Pops on different channels in the same cycle SHALL be independent; a broadcast push SHALL coexist with pops on any channels.
REQ-025 Outputs SHALL be X-free after the first reset edge.

Reset
REQ-026 On a rising edge with rst=1, all FIFOs SHALL empty: level=0, dout_valid=4'b0000, dout=32'h0, discarding stored data.
REQ-027 Reset asserted mid-stream SHALL take priority over any concurrent push or pop on that edge.
REQ-028 In the first cycle after rst deasserts, din_ready SHALL be 1 for any dsel.

Verification
REQ-029 Unicast: reset, send 8'hA5 to dsel=3'b010 with dout_ready=0 -> next cycle dout_valid=4'b0100, dout[23:16]=8'hA5, level=8'b00_01_00_00.
REQ-030 Full: write 8'h11, 8'h22 to channel 1, dout_ready=0 -> level[3:2]=2, din_ready=0 for dsel=3'b001 and 3'b1xx, 1 for dsel=3'b000; set dout_ready[1]=1 -> pops 8'h11 then 8'h22 in order.
REQ-031 Broadcast: reset, send 8'h3C with dsel=3'b100 -> next cycle dout_valid=4'b1111, every dout byte=8'h3C; with channel 3 full, broadcast stalls (din_ready=0) until channel 3 pops.
REQ-032 Same-cycle push/pop: channel 0 holds 8'h01, push 8'h02 with dout_ready[0]=1 -> level[1:0] stays 1, dout[7:0]=8'h02 next cycle.
REQ-033 Reset mid-operation: all channels at level 2, assert rst with din_valid=1 and dout_ready=4'hF -> after the edge level=0, dout=0, dout_valid=0, din_ready=0 while rst=1, 1 after release.
